// File: rtl/spmv_rd_arbiter.sv
// rtl/spmv_rd_arbiter.sv - round-robin AR/R arbiter sharing one narrow read port
//
// Purpose:
//   Shares the single narrow read port of the SpMV burst-aggregating read demux
//   among NUM_REQ requesters. AR requests are granted round-robin with exactly
//   one transaction outstanding. R beats are routed back only to the granted
//   requester.
//
// Optional build macro:
//   SPMV_RD_ARB_LOCALITY_EN - prefer requesters whose address falls inside the
//   most recently granted WINDOW_BYTES window, so the downstream burst buffer is
//   reused. At most MAX_STREAK locality grants happen in a row before one plain
//   round-robin grant is forced. When the macro is undefined the arbiter is pure
//   round-robin and the window/streak logic is absent.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_axi_ar*         - per-requester AR channel (slice i = requester i)
//   s_axi_r*          - per-requester R channel; data/resp broadcast,
//                       valid/last gated by the current grant
//   m_axi_ar*         - registered single-beat AR towards the shared port
//   m_axi_r*          - R channel from the shared port
module spmv_rd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 48,
    parameter int DATA_WIDTH   = 32,
    parameter int WINDOW_BYTES = 512,
    parameter int MAX_STREAK   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [NUM_REQ-1:0]            s_axi_arvalid,
    output logic [NUM_REQ-1:0]            s_axi_arready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] s_axi_rdata,
    output logic [NUM_REQ*2-1:0]          s_axi_rresp,
    output logic [NUM_REQ-1:0]            s_axi_rlast,
    output logic [NUM_REQ-1:0]            s_axi_rvalid,
    input  logic [NUM_REQ-1:0]            s_axi_rready,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || WINDOW_BYTES < 1 || (WINDOW_BYTES & (WINDOW_BYTES - 1)) != 0 ||
        MAX_STREAK < 1) begin : g_bad_cfg
        $error("spmv_rd_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         grant_inc;
    logic [PW-1:0]         rr_winner;
    logic [PW-1:0]         winner;
    logic                  any_valid;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];

    // First set bit of vec at or after start, wrapping modulo NUM_REQ.
    // Returns {found, index}.
    function automatic logic [PW:0] pick_from(input logic [NUM_REQ-1:0] vec,
                                              input logic [PW-1:0]      start);
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic [PW-1:0] sel;
        logic          found;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, start} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && vec[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign {any_valid, rr_winner} = pick_from(s_axi_arvalid, rr_ptr);

    assign grant_inc = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + PW'(1);

`ifdef SPMV_RD_ARB_LOCALITY_EN
    localparam int                    SW       = $clog2(MAX_STREAK + 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~ADDR_WIDTH'(WINDOW_BYTES - 1);

    logic [ADDR_WIDTH-1:0] last_win;
    logic                  last_win_vld;
    logic [SW-1:0]         streak;
    logic [NUM_REQ-1:0]    hit;
    logic [PW-1:0]         loc_winner;
    logic                  loc_found;
    logic                  loc_sel;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hit[i] = s_axi_arvalid[i] & last_win_vld & ((req_addr[i] & WIN_MASK) == last_win);
        end
    end

    assign {loc_found, loc_winner} = pick_from(hit, rr_ptr);

    // A full streak suppresses locality for one grant so far-window requesters
    // cannot be starved by a requester streaming inside one window.
    assign loc_sel = loc_found && (streak != SW'(MAX_STREAK));
    assign winner  = loc_sel ? loc_winner : rr_winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_win     <= '0;
            last_win_vld <= 1'b0;
            streak       <= '0;
        end else if (state == S_IDLE && any_valid) begin
            last_win     <= req_addr[winner] & WIN_MASK;
            last_win_vld <= 1'b1;
            streak       <= loc_sel ? streak + SW'(1) : '0;
        end
    end
`else
    assign winner = rr_winner;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The requester-side ready is asserted whenever anyone is
    // valid in IDLE, so a valid requester always completes its handshake there.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (any_valid)     state_next = S_ADDR;
            S_ADDR: if (m_axi_arready) state_next = S_DATA;
            S_DATA: if (last_beat)     state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    // Output logic. Everything is held low during reset so an in-flight beat is
    // dropped rather than accepted on the reset cycle.
    always_comb begin
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        s_axi_rlast   = '0;
        m_axi_rready  = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        s_axi_arready[winner] = 1'b1;
                    end
                end
                S_DATA: begin
                    s_axi_rvalid[grant] = m_axi_rvalid;
                    s_axi_rlast[grant]  = m_axi_rlast;
                    m_axi_rready        = s_axi_rready[grant];
                end
                default: ;
            endcase
        end
    end

    assign last_beat = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    // Grant, pointer and registered AR.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            grant         <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant         <= winner;
                        m_axi_araddr  <= req_addr[winner];
                        m_axi_arvalid <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (last_beat) begin
                        rr_ptr <= grant_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_arlen = 8'd0;
    assign s_axi_rdata = {NUM_REQ{m_axi_rdata}};
    assign s_axi_rresp = {NUM_REQ{m_axi_rresp}};

endmodule
